// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin acceptor FSM states and the
// default coin qualification constants also used by the controller bench.
package vend_pkg;

    localparam int COIN_MIN_W   = 3;   // shortest synchronised high time of a real coin
    localparam int COIN_MAX_W   = 20;  // longest valid high time; beyond this is a jam
    localparam int COIN_HOLDOFF = 4;   // dead time after every event

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_JAM     = 2'd2,
        ST_HOLDOFF = 2'd3
    } coin_acc_state_t;

endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor inputs and event outputs of the coin acceptor front end.
// master: the side that owns the coin slot sensors and consumes events.
// slave:  the coin acceptor itself.
interface coin_acceptor_if;

    logic sense1_raw;
    logic sense2_raw;
    logic coin1;
    logic coin2;
    logic reject;
    logic jam;

    modport master (
        output sense1_raw,
        output sense2_raw,
        input  coin1,
        input  coin2,
        input  reject,
        input  jam
    );

    modport slave (
        input  sense1_raw,
        input  sense2_raw,
        output coin1,
        output coin2,
        output reject,
        output jam
    );

endinterface

// File: rtl/coin_acceptor_sync.sv
// Two-flop synchroniser followed by a registered rise detector for one
// asynchronous coin sensor line. level and rise are time-aligned.
module coin_sync (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic       meta_r;
    logic       sync_r;
    logic       level_r;
    logic       rise_r;
    // Marks which pipeline stages hold real samples since reset; a rise is
    // only reported once level_r has been loaded from a valid sample, so a
    // line that is already high when reset is released never looks fresh.
    logic [2:0] vld_r;

    // Synchronise, keep edge history and register the rise indication.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_r  <= 1'b0;
            sync_r  <= 1'b0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            vld_r   <= 3'b000;
        end else begin
            meta_r  <= raw;
            sync_r  <= meta_r;
            level_r <= sync_r;
            rise_r  <= vld_r[2] & sync_r & ~level_r;
            vld_r   <= {vld_r[1:0], 1'b1};
        end
    end

    assign level = level_r;
    assign rise  = rise_r;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: qualifies the two coin sensor lines by pulse
// width, rejects short, dual-channel and jammed events, and enforces a
// hold-off window so the controller sees each coin exactly once.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int MIN_W   = COIN_MIN_W,
    parameter int MAX_W   = COIN_MAX_W,
    parameter int HOLDOFF = COIN_HOLDOFF
) (
    input  logic           clk,
    input  logic           rst,
    coin_acceptor_if.slave bus
);

    localparam int CW = $clog2(MAX_W + 2);
    localparam int HW = $clog2(HOLDOFF + 1);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MIN  = CW'(MIN_W);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_W);
    localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_W + 1);
    localparam logic [HW-1:0] HOLD_LD  = HW'(HOLDOFF);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
    localparam logic [HW-1:0] HOLD_Z   = HW'(0);

    logic s1_s, s2_s, r1_s, r2_s;

    coin_sync u_sync1 (.clk(clk), .rst(rst), .raw(bus.sense1_raw), .level(s1_s), .rise(r1_s));
    coin_sync u_sync2 (.clk(clk), .rst(rst), .raw(bus.sense2_raw), .level(s2_s), .rise(r2_s));

    coin_acc_state_t state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [HW-1:0]   hold_r, hold_s;
    logic            ch_r, ch_s;        // 0: 1-unit slot, 1: 2-unit slot
    logic            dual_r, dual_s;
    logic            coin1_r, coin1_s;
    logic            coin2_r, coin2_s;
    logic            reject_r, reject_s;
    logic            jam_r, jam_s;
    logic            act_s, other_s, dual_now_s;

    // Next-state, counter and event decode for the qualification FSM.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        hold_s     = hold_r;
        ch_s       = ch_r;
        dual_s     = dual_r;
        coin1_s    = 1'b0;
        coin2_s    = 1'b0;
        reject_s   = 1'b0;
        jam_s      = jam_r;
        act_s      = ch_r ? s2_s : s1_s;
        other_s    = ch_r ? s1_s : s2_s;
        dual_now_s = dual_r | other_s;

        case (state_r)
            ST_IDLE: begin
                if (r1_s && r2_s) begin
                    state_s = ST_MEASURE;
                    ch_s    = 1'b0;
                    cnt_s   = CNT_ONE;
                    dual_s  = 1'b1;
                end else if (r1_s) begin
                    state_s = ST_MEASURE;
                    ch_s    = 1'b0;
                    cnt_s   = CNT_ONE;
                    dual_s  = 1'b0;
                end else if (r2_s) begin
                    state_s = ST_MEASURE;
                    ch_s    = 1'b1;
                    cnt_s   = CNT_ONE;
                    dual_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                dual_s = dual_now_s;
                if (act_s) begin
                    if (cnt_r == CNT_MAX) begin
                        // One more high cycle would exceed MAX_W: jam.
                        state_s  = ST_JAM;
                        cnt_s    = CNT_SAT;
                        jam_s    = 1'b1;
                        reject_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = ST_HOLDOFF;
                    hold_s  = HOLD_LD;
                    if ((cnt_r >= CNT_MIN) && (cnt_r <= CNT_MAX) && !dual_now_s) begin
                        if (ch_r) begin
                            coin2_s = 1'b1;
                        end else begin
                            coin1_s = 1'b1;
                        end
                    end else begin
                        reject_s = 1'b1;
                    end
                end
            end
            ST_JAM: begin
                if (!s1_s && !s2_s) begin
                    state_s = ST_HOLDOFF;
                    hold_s  = HOLD_LD;
                    jam_s   = 1'b0;
                end else begin
                    jam_s = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (hold_r == HOLD_Z) begin
                    state_s = ST_IDLE;
                end else begin
                    hold_s = hold_r - HOLD_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                jam_s   = 1'b0;
            end
        endcase
    end

    // State, counters and registered event outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            hold_r   <= '0;
            ch_r     <= 1'b0;
            dual_r   <= 1'b0;
            coin1_r  <= 1'b0;
            coin2_r  <= 1'b0;
            reject_r <= 1'b0;
            jam_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            hold_r   <= hold_s;
            ch_r     <= ch_s;
            dual_r   <= dual_s;
            coin1_r  <= coin1_s;
            coin2_r  <= coin2_s;
            reject_r <= reject_s;
            jam_r    <= jam_s;
        end
    end

    assign bus.coin1  = coin1_r;
    assign bus.coin2  = coin2_r;
    assign bus.reject = reject_r;
    assign bus.jam    = jam_r;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor with default parameters (3/20/4). Each vector
// pushes its expected output events (kind and clock edge) into a queue;
// every cycle the observed events are popped and compared in order.
// Edge numbers: sensor values driven when edge_n == e are sampled at edge
// e+1. A raw pulse starting at table offset S with width W therefore has
// its coin/reject at base + S + W + 4 and a jam at base + S + MAX_W + 4.
module tb_coin_acceptor;
    import vend_pkg::*;

    typedef enum logic [2:0] {
        EV_NONE, EV_COIN1, EV_COIN2, EV_REJ, EV_JAM_ON, EV_JAM_OFF
    } ev_t;

    typedef struct {
        ev_t kind;
        int  at;
    } exp_t;

    typedef struct {
        int  s1_start;
        int  s1_len;
        int  s2_start;
        int  s2_len;
        ev_t ev0;
        int  off0;
        ev_t ev1;
        int  off1;
        ev_t ev2;
        int  off2;
    } vec_t;

    logic clk;
    logic rst;
    int   edge_n = 0;
    int   checks = 0;
    int   failures = 0;
    bit   jam_prev = 1'b0;
    exp_t sb_q[$];
    vec_t vecs[12];

    coin_acceptor_if bus();

    coin_acceptor #(
        .MIN_W  (COIN_MIN_W),
        .MAX_W  (COIN_MAX_W),
        .HOLDOFF(COIN_HOLDOFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic string ev_name(input ev_t k);
        case (k)
            EV_COIN1:   return "coin1";
            EV_COIN2:   return "coin2";
            EV_REJ:     return "reject";
            EV_JAM_ON:  return "jam_rise";
            EV_JAM_OFF: return "jam_fall";
            default:    return "none";
        endcase
    endfunction

    task automatic push(input ev_t k, input int at);
        exp_t e;
        if (k != EV_NONE) begin
            e.kind = k;
            e.at   = at;
            sb_q.push_back(e);
        end
    endtask

    task automatic match(input ev_t k);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL event: got %s at edge %0d, required no event", ev_name(k), edge_n);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != k || e.at != edge_n) begin
                failures++;
                $display("FAIL event: got %s at edge %0d, required %s at edge %0d",
                         ev_name(k), edge_n, ev_name(e.kind), e.at);
            end
        end
    endtask

    task automatic observe();
        int n;
        n = 0;
        if (bus.coin1 === 1'b1)  n++;
        if (bus.coin2 === 1'b1)  n++;
        if (bus.reject === 1'b1) n++;
        checks++;
        if (n > 1) begin
            failures++;
            $display("FAIL exclusive: %0d event outputs high at edge %0d, required at most 1", n, edge_n);
        end
        if (bus.coin1 === 1'b1)                 match(EV_COIN1);
        if (bus.coin2 === 1'b1)                 match(EV_COIN2);
        if (bus.reject === 1'b1)                match(EV_REJ);
        if (bus.jam === 1'b1 && !jam_prev)      match(EV_JAM_ON);
        if (bus.jam !== 1'b1 && jam_prev)       match(EV_JAM_OFF);
        jam_prev = (bus.jam === 1'b1);
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
    endtask

    task automatic drain(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d expected events never seen, first %s at edge %0d (now %0d)",
                     name, sb_q.size(), ev_name(sb_q[0].kind), sb_q[0].at, edge_n);
        end
        sb_q.delete();
    endtask

    task automatic chk(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int base;
        tick();
        base = edge_n;
        push(v.ev0, base + v.off0);
        push(v.ev1, base + v.off1);
        push(v.ev2, base + v.off2);
        for (int off = 0; off < 60; off++) begin
            bus.sense1_raw = (off >= v.s1_start) && (off < v.s1_start + v.s1_len);
            bus.sense2_raw = (off >= v.s2_start) && (off < v.s2_start + v.s2_len);
            tick();
        end
        drain($sformatf("vec%0d", idx));
    endtask

    initial begin
        int base;

        //             s1 start/len  s2 start/len  events (kind, edge offset)
        vecs[0]  = '{0, 5,   0, 0,   EV_COIN1, 9,  EV_NONE, 0,    EV_NONE, 0};     // valid 1-unit coin
        vecs[1]  = '{0, 0,   0, 2,   EV_REJ, 6,    EV_NONE, 0,    EV_NONE, 0};     // short pulse
        vecs[2]  = '{0, 6,   1, 2,   EV_REJ, 10,   EV_NONE, 0,    EV_NONE, 0};     // other slot high mid-measure
        vecs[3]  = '{0, 25,  0, 0,   EV_REJ, 24,   EV_JAM_ON, 24, EV_JAM_OFF, 29}; // jam
        vecs[4]  = '{0, 0,   0, 3,   EV_COIN2, 7,  EV_NONE, 0,    EV_NONE, 0};     // exactly MIN_W
        vecs[5]  = '{0, 20,  0, 0,   EV_COIN1, 24, EV_NONE, 0,    EV_NONE, 0};     // exactly MAX_W
        vecs[6]  = '{0, 0,   0, 21,  EV_REJ, 24,   EV_JAM_ON, 24, EV_JAM_OFF, 25}; // MAX_W + 1
        vecs[7]  = '{0, 5,   0, 5,   EV_REJ, 9,    EV_NONE, 0,    EV_NONE, 0};     // both rise together
        vecs[8]  = '{0, 1,   0, 0,   EV_REJ, 5,    EV_NONE, 0,    EV_NONE, 0};     // single-cycle pulse
        vecs[9]  = '{0, 5,   11, 5,  EV_COIN1, 9,  EV_COIN2, 20,  EV_NONE, 0};     // minimum coin spacing
        vecs[10] = '{0, 5,   10, 5,  EV_COIN1, 9,  EV_NONE, 0,    EV_NONE, 0};     // one cycle too close
        vecs[11] = '{0, 0,   0, 4,   EV_COIN2, 8,  EV_NONE, 0,    EV_NONE, 0};     // valid 2-unit coin

        // Reset with a line already high: nothing may come out of it.
        rst = 1'b0;
        bus.sense1_raw = 1'b1;
        bus.sense2_raw = 1'b0;
        repeat (3) tick();
        chk("reset_coin1", bus.coin1, 1'b0);
        chk("reset_coin2", bus.coin2, 1'b0);
        chk("reset_reject", bus.reject, 1'b0);
        chk("reset_jam", bus.jam, 1'b0);
        rst = 1'b1;
        repeat (30) tick();
        bus.sense1_raw = 1'b0;
        repeat (10) tick();
        drain("reset_high_line");

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        // Same-slot retrigger inside hold-off is ignored; a later coin counts.
        tick();
        base = edge_n;
        push(EV_COIN2, base + 9);
        push(EV_COIN2, base + 27);
        for (int off = 0; off < 50; off++) begin
            bus.sense2_raw = (off < 5) || (off == 10) || (off >= 19 && off < 23);
            tick();
        end
        drain("holdoff");

        // Reset while cnt == 3 during a 5-cycle coin discards the event.
        tick();
        base = edge_n;
        for (int off = 0; off < 40; off++) begin
            bus.sense1_raw = (off < 5);
            rst = (off == 6 || off == 7) ? 1'b0 : 1'b1;
            tick();
        end
        drain("reset_mid_measure");

        // The acceptor must be back in IDLE and accept a normal coin on time.
        run_vec(vecs[0], 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage for the vending machine controller. It turns the two asynchronous coin-slot sensor lines into clean, single-cycle `coin1`/`coin2` pulses, which the controller consumes directly. The block synchronises and pulse-width-qualifies each sensor line. It rejects short, dual-channel and stuck (jammed) events, and enforces a hold-off window after every event so that the controller never sees a duplicate coin.

## Interface
Parameters:
- `MIN_W`, default 3: minimum synchronised high width, in cycles, for a valid coin.
- `MAX_W`, default 20: maximum valid width; a longer high time is a jam. Constraint: 1 ≤ MIN_W ≤ MAX_W.
- `HOLDOFF`, default 4: cycles during which inputs are ignored after any event; must be ≥ 1.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-low reset.
- `sense1_raw` in 1: asynchronous sensor for the 1-unit coin slot.
- `sense2_raw` in 1: asynchronous sensor for the 2-unit coin slot.
- `coin1` out 1: one-cycle pulse when a valid 1-unit coin is accepted.
- `coin2` out 1: one-cycle pulse when a valid 2-unit coin is accepted.
- `reject` out 1: one-cycle pulse when an event is rejected (short, dual-channel or jam entry).
- `jam` out 1: level, high while a jam is in progress.

## Operation
- Each raw line passes through a 2-flop synchroniser, giving `s1`/`s2`, followed by a registered rise detector.
- FSM states: IDLE, MEASURE, JAM, HOLDOFF.
- **IDLE**
  - A rising edge on exactly one of `s1`/`s2` moves to MEASURE. It latches `ch` (the active channel), sets `cnt`=1 and `dual`=0.
  - Rising edges on both channels in the same cycle move to MEASURE with `dual`=1.
  - A line that is already high without a fresh rising edge never starts an event.
- **MEASURE**
  - While `s[ch]` is high, `cnt` increments (saturating at MAX_W+1).
  - Any high on the other channel sets `dual`.
  - When `cnt` would exceed MAX_W, the FSM moves to JAM.
  - When `s[ch]` is sampled low, the FSM moves to HOLDOFF. On the next cycle, exactly one of the following is asserted:
    - `coin[ch]`, if MIN_W ≤ `cnt` ≤ MAX_W and `dual`=0;
    - otherwise `reject`.
- **JAM**
  - `reject` pulses once on entry.
  - `jam` stays high until `s1` and `s2` are both low; then the FSM moves to HOLDOFF and `jam` drops.
- **HOLDOFF**
  - A down-counter loaded with HOLDOFF; all sensor activity is ignored.
  - At zero, the FSM returns to IDLE.
  - Edge-detector history keeps updating, so a line still high on return to IDLE does not retrigger.
- `cnt` width is $clog2(MAX_W+2). The hold-off counter width is $clog2(HOLDOFF+1).
- `coin1`, `coin2` and `reject` are mutually exclusive; at most one event output is issued per event.

## Timing
- All outputs are registered.
- Reset values: `coin1`=`coin2`=`reject`=`jam`=0. Reset also forces the FSM to IDLE, clears `cnt`, the hold-off counter, the synchronisers and the edge history.
- Reset mid-operation (any state) discards the event in progress; no pulse is emitted on the cycle reset deasserts.
- Synchroniser latency is 2 cycles; the rise detector adds 1 cycle.
- A raw pulse of W cycles yields `cnt`=W.
- `coin`/`reject` is high during the cycle after MEASURE samples `s[ch]` low, i.e. raw falling edge + 3 cycles.
- `jam` rises on the cycle after `cnt` reaches MAX_W+1, i.e. synchronised rise + MAX_W + 1 cycles, together with the `reject` pulse.
- Minimum spacing between two accepted coins is W + HOLDOFF + 2 cycles.

## Structure
- Package `vend_pkg` holds:
  - the FSM enum `coin_acc_state_t` (IDLE, MEASURE, JAM, HOLDOFF);
  - the default constants `COIN_MIN_W`, `COIN_MAX_W` and `COIN_HOLDOFF`, shared with the controller bench.
- Sub-module `coin_sync`: 2-flop synchroniser plus registered rise detector, with outputs `level` and `rise`. It is instantiated once per sensor line.
- The FSM, counters and output registers live in `coin_acceptor`.

## Test plan
All scenarios use the default parameters (3/20/4).
- **Reset:** hold `rst`=0 for 3 cycles with `sense1_raw`=1, then release → all outputs stay 0 and no `coin1` is produced from the already-high line.
- **Valid coin:** `sense1_raw` high for 5 cycles → exactly one `coin1` pulse, at raw fall + 3; `coin2`, `reject` and `jam` stay 0.
- **Short pulse and dual channel:** `sense2_raw` high for 2 cycles → one `reject`, no `coin2`. Separately, `sense1_raw` high for 6 cycles with `sense2_raw` high on cycles 2–3 → one `reject`, no coin.
- **Jam:** `sense1_raw` high for 25 cycles → `jam` and a single `reject` at synchronised rise + 21. `jam` clears when the line drops, followed by 4 ignored cycles and no `coin1`.
- **Hold-off:** `sense2_raw` high for 5 cycles, then a 1-cycle pulse inside HOLDOFF → one `coin2` only. A 4-cycle pulse after HOLDOFF → a second `coin2`.
- **Reset mid-measure:** assert `rst`=0 at `cnt`=3 during a 5-cycle coin → no `coin`/`reject`, FSM in IDLE.
